// File: rtl/yuv_chroma_subsample.sv
// YUV444 -> 444/422/420 chroma subsampler with interleaved chroma output and a fixed 3-cycle latency.
// Define YUV_CHROMA_AVG_EN for averaging filters; the default build decimates (keeps the even pixel's chroma).
module yuv_chroma_subsample #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic [1:0]      cfg_mode,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_y,
    input  logic [BITS-1:0] in_u,
    input  logic [BITS-1:0] in_v,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_y,
    output logic [BITS-1:0] out_c,
    output logic [BITS-1:0] out_v,
    output logic            out_c_valid,
    output logic            out_c_sel
);
    localparam int DEPTH = (WIDTH / 2 > 1) ? WIDTH / 2 : 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam logic [LW-1:0] LINE_MAX = LW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        MODE_444 = 2'd0,
        MODE_422 = 2'd1,
        MODE_420 = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

`ifdef YUV_CHROMA_AVG_EN
    function automatic logic [BITS-1:0] avg(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [BITS:0] s;
        s = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, 1'b1};
        return s[BITS:1];
    endfunction
`endif

    logic            vs_q, href_q, par_r, buf_ok_r;
    mode_t           mode_r;
    logic [LW-1:0]   line_r;
    logic [AW-1:0]   k_r;
    logic            vs_rise, eff_lodd, eff_ok;
    mode_t           eff_mode;

    logic            s1_href, s1_vs, s1_odd, s1_lodd, s1_ok;
    mode_t           s1_mode;
    logic [BITS-1:0] s1_y, s1_u, s1_v;
    logic [AW-1:0]   s1_k;

    logic            s2_href, s2_vs, s2_odd, s2_lodd, s2_ok;
    mode_t           s2_mode;
    logic [BITS-1:0] s2_y, s2_pu, s2_pv;
    logic [AW-1:0]   s2_k;

    logic [2*BITS-1:0] mem [DEPTH];
    logic [2*BITS-1:0] buf_q;

    logic [BITS-1:0] pair_u, pair_v, bufd, vert;
    logic [BITS-1:0] n_y, n_c, n_v;
    logic            n_val, n_sel, subsample;

    // A vsync rise overrides the registered frame state for the pixel arriving with it.
    assign vs_rise  = in_vsync & ~vs_q;
    assign eff_mode = vs_rise ? mode_t'(cfg_mode) : mode_r;
    assign eff_lodd = vs_rise ? 1'b0 : line_r[0];
    assign eff_ok   = vs_rise ? 1'b0 : buf_ok_r;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            href_q   <= 1'b0;
            mode_r   <= MODE_444;
            line_r   <= '0;
            par_r    <= 1'b0;
            k_r      <= '0;
            buf_ok_r <= 1'b0;
        end else begin
            vs_q   <= in_vsync;
            href_q <= in_href;
            mode_r <= eff_mode;
            if (vs_rise)
                line_r <= '0;
            else if (href_q && !in_href && line_r != LINE_MAX)
                line_r <= line_r + LW'(1);
            par_r    <= in_href ? ~par_r : 1'b0;
            k_r      <= !in_href ? '0 : (par_r ? k_r + AW'(1) : k_r);
            buf_ok_r <= eff_ok | (in_href && eff_mode == MODE_420 && !eff_lodd);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_href <= 1'b0; s1_vs <= 1'b0; s1_odd <= 1'b0; s1_lodd <= 1'b0; s1_ok <= 1'b0;
            s1_mode <= MODE_444; s1_y <= '0; s1_u <= '0; s1_v <= '0; s1_k <= '0;
        end else begin
            s1_href <= in_href; s1_vs <= in_vsync; s1_odd <= par_r; s1_lodd <= eff_lodd;
            s1_ok   <= eff_ok; s1_mode <= eff_mode; s1_y <= in_y; s1_u <= in_u; s1_v <= in_v;
            s1_k    <= k_r;
        end
    end

    // The odd partner of an even pixel in stage 1 is the pixel currently at the input.
    always_comb begin
        pair_u    = s1_u;
        pair_v    = s1_v;
`ifdef YUV_CHROMA_AVG_EN
        if (in_href && par_r) begin
            pair_u = avg(s1_u, in_u);
            pair_v = avg(s1_v, in_v);
        end
`endif
        subsample = (s1_mode == MODE_422) || (s1_mode == MODE_420);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_href <= 1'b0; s2_vs <= 1'b0; s2_odd <= 1'b0; s2_lodd <= 1'b0; s2_ok <= 1'b0;
            s2_mode <= MODE_444; s2_y <= '0; s2_pu <= '0; s2_pv <= '0; s2_k <= '0;
        end else begin
            s2_href <= s1_href; s2_vs <= s1_vs; s2_odd <= s1_odd; s2_lodd <= s1_lodd;
            s2_ok   <= s1_ok; s2_mode <= s1_mode; s2_y <= s1_y; s2_k <= s1_k;
            if (!subsample) begin
                s2_pu <= s1_u;
                s2_pv <= s1_v;
            end else if (!s1_odd) begin
                s2_pu <= pair_u;
                s2_pv <= pair_v;
            end
        end
    end

    always_ff @(posedge pclk) begin
        buf_q <= mem[s1_k];
        if (s2_href && !s2_odd && s2_mode == MODE_420 && !s2_lodd)
            mem[s2_k] <= {s2_pu, s2_pv};
    end

    always_comb begin
        bufd  = s2_odd ? buf_q[BITS-1:0] : buf_q[2*BITS-1:BITS];
`ifdef YUV_CHROMA_AVG_EN
        vert  = avg(bufd, s2_odd ? s2_pv : s2_pu);
`else
        vert  = bufd;
`endif
        n_y   = '0;
        n_c   = '0;
        n_v   = '0;
        n_val = 1'b0;
        n_sel = 1'b0;
        if (s2_href) begin
            n_y = s2_y;
            case (s2_mode)
                MODE_422: begin
                    n_c   = s2_odd ? s2_pv : s2_pu;
                    n_val = 1'b1;
                    n_sel = s2_odd;
                end
                MODE_420: begin
                    if (s2_lodd && s2_ok) begin
                        n_c   = vert;
                        n_val = 1'b1;
                        n_sel = s2_odd;
                    end
                end
                default: begin
                    n_c   = s2_pu;
                    n_v   = s2_pv;
                    n_val = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href <= 1'b0; out_vsync <= 1'b0; out_y <= '0; out_c <= '0; out_v <= '0;
            out_c_valid <= 1'b0; out_c_sel <= 1'b0;
        end else begin
            out_href <= s2_href; out_vsync <= s2_vs; out_y <= n_y; out_c <= n_c; out_v <= n_v;
            out_c_valid <= n_val; out_c_sel <= n_sel;
        end
    end
endmodule
